// File: rtl/freelist_int.sv
// Integer PRF free list for rename: multi-lane allocate/release with branch checkpoints.
// Define FREELIST_INT_ASSERT_EN to enable simulation assertions on illegal usage.
module freelist_int #(
  parameter int unsigned RENAME_WIDTH       = 3,
  parameter int unsigned PRF_INT_SIZE       = 64,
  parameter int unsigned PRF_INT_INDEX_SIZE = 6,
  parameter int unsigned CP_NUM             = 4,
  parameter int unsigned CP_INDEX_SIZE      = 2
) (
  input  logic                                               clock,
  input  logic                                               reset,
  input  logic                                               check,
  input  logic                                               recover,
  input  logic [CP_INDEX_SIZE-1:0]                           check_idx,
  input  logic [CP_INDEX_SIZE-1:0]                           recover_idx,
  input  logic [RENAME_WIDTH-1:0]                            prf_replace_valid,
  input  logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]    prf_replace,
  input  logic [RENAME_WIDTH-1:0]                            prf_req,
  output logic [RENAME_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]    prf_out,
  output logic                                               allocatable
);

  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned CNT_W     = PRF_INT_INDEX_SIZE + 1;
  localparam logic [PRF_INT_SIZE-1:0] FREE_RESET = {PRF_INT_SIZE{1'b1}} << ARCH_REGS;

  logic [PRF_INT_SIZE-1:0]              free_q, free_d;
  logic [CP_NUM-1:0][PRF_INT_SIZE-1:0]  alloc_since_q, alloc_since_d;
  logic [PRF_INT_SIZE-1:0]              avail;
  logic [PRF_INT_SIZE-1:0]              grant;
  logic [CNT_W-1:0]                     free_cnt;
  logic [CNT_W-1:0]                     req_cnt;
  logic                                 found;
  logic                                 do_alloc;

  // Each requesting lane takes the lowest index not already taken by a lower lane.
  always_comb begin
    avail       = free_q;
    grant       = '0;
    prf_out     = '0;
    free_cnt    = '0;
    req_cnt     = '0;
    found       = 1'b0;
    for (int b = 0; b < int'(PRF_INT_SIZE); b++) begin
      free_cnt = free_cnt + CNT_W'(free_q[b]);
    end
    for (int l = 0; l < int'(RENAME_WIDTH); l++) begin
      req_cnt = req_cnt + CNT_W'(prf_req[l]);
      found   = 1'b0;
      if (prf_req[l]) begin
        for (int b = 0; b < int'(PRF_INT_SIZE); b++) begin
          if (!found && avail[b]) begin
            prf_out[l] = PRF_INT_INDEX_SIZE'(b);
            avail[b]   = 1'b0;
            grant[b]   = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
    allocatable = (free_cnt >= req_cnt);
  end

  // Releases and recovery set bits first; a grant then clears whatever it takes.
  always_comb begin
    free_d        = free_q;
    alloc_since_d = alloc_since_q;
    do_alloc      = allocatable && !recover;
    for (int l = 0; l < int'(RENAME_WIDTH); l++) begin
      if (prf_replace_valid[l] && (prf_replace[l] != '0)) begin
        free_d[prf_replace[l]] = 1'b1;
      end
    end
    if (recover) begin
      free_d = free_d | alloc_since_q[recover_idx];
    end
    if (do_alloc) begin
      free_d = free_d & ~grant;
      for (int c = 0; c < int'(CP_NUM); c++) begin
        alloc_since_d[c] = alloc_since_q[c] | grant;
      end
    end
    free_d[0] = 1'b0;
    // A new checkpoint excludes this cycle's grants; recovery of the same slot wins.
    if (check && !(recover && (recover_idx == check_idx))) begin
      alloc_since_d[check_idx] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_q        <= FREE_RESET;
      alloc_since_q <= '0;
    end else begin
      free_q        <= free_d;
      alloc_since_q <= alloc_since_d;
    end
  end

`ifdef FREELIST_INT_ASSERT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int l = 0; l < int'(RENAME_WIDTH); l++) begin
        if (prf_replace_valid[l]) begin
          assert (prf_replace[l] != '0) else $error("freelist_int: release of p0");
          assert (!free_q[prf_replace[l]]) else $error("freelist_int: release of free register");
        end
      end
      assert (!((prf_req != '0) && !allocatable)) else $error("freelist_int: request while not allocatable");
      assert (!(check && recover && (check_idx == recover_idx)))
        else $error("freelist_int: check and recover on same slot");
    end
  end
`else
  // Assertions compiled out; function unchanged.
`endif

endmodule

// File: tb/tb_freelist_int.sv
// Self-checking bench for freelist_int: directed scenarios then random traffic vs a set-based model.
module tb_freelist_int;

  localparam int RW  = 3;
  localparam int PS  = 64;
  localparam int IW  = 6;
  localparam int CPN = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   check, recover;
  logic [1:0]             check_idx, recover_idx;
  logic [RW-1:0]          prf_replace_valid;
  logic [RW-1:0][IW-1:0]  prf_replace;
  logic [RW-1:0]          prf_req;
  logic [RW-1:0][IW-1:0]  prf_out;
  logic                   allocatable;

  freelist_int dut (
    .clock             (clock),
    .reset             (reset),
    .check             (check),
    .recover           (recover),
    .check_idx         (check_idx),
    .recover_idx       (recover_idx),
    .prf_replace_valid (prf_replace_valid),
    .prf_replace       (prf_replace),
    .prf_req           (prf_req),
    .prf_out           (prf_out),
    .allocatable       (allocatable)
  );

  always #5 clock = ~clock;

  bit m_free[PS];
  bit m_as[CPN][PS];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Expected outputs: sorted list of free registers, k-th requester gets the k-th entry.
  function automatic void model_outputs(output logic [RW-1:0][IW-1:0] eo, output logic ea);
    int q[$];
    int k;
    for (int i = 0; i < PS; i++) if (m_free[i]) q.push_back(i);
    eo = '0;
    k  = 0;
    for (int l = 0; l < RW; l++) begin
      if (prf_req[l]) begin
        if (k < q.size()) eo[l] = IW'(q[k]);
        k++;
      end
    end
    ea = (q.size() >= k);
  endfunction

  task automatic idle();
    check = 0; recover = 0; check_idx = 0; recover_idx = 0;
    prf_replace_valid = '0; prf_replace = '0; prf_req = '0;
  endtask

  task automatic step(input string tag);
    logic [RW-1:0][IW-1:0] eo;
    logic                  ea;
    bit                    nf[PS];
    @(negedge clock);
    model_outputs(eo, ea);
    if (!reset) begin
      for (int l = 0; l < RW; l++) chk($sformatf("%s.out%0d", tag, l), int'(prf_out[l]), int'(eo[l]));
      chk($sformatf("%s.alloc", tag), int'(allocatable), int'(ea));
    end
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < PS; i++) m_free[i] = (i >= 32);
      for (int c = 0; c < CPN; c++) for (int i = 0; i < PS; i++) m_as[c][i] = 0;
    end else begin
      nf = m_free;
      for (int l = 0; l < RW; l++)
        if (prf_replace_valid[l] && prf_replace[l] != 0) nf[prf_replace[l]] = 1;
      if (recover) for (int i = 0; i < PS; i++) if (m_as[recover_idx][i]) nf[i] = 1;
      if (ea && !recover) begin
        for (int l = 0; l < RW; l++) begin
          if (prf_req[l]) begin
            nf[eo[l]] = 0;
            for (int c = 0; c < CPN; c++) m_as[c][eo[l]] = 1;
          end
        end
      end
      if (check && !(recover && check_idx == recover_idx))
        for (int i = 0; i < PS; i++) m_as[check_idx][i] = 0;
      m_free = nf;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step("rst");
    reset = 0;
  endtask

  initial begin
    int cand[$];
    idle();
    reset = 1;
    step("rst0");
    step("rst1");
    reset = 0;

    // Single middle-lane request
    prf_req = 3'b010;
    #1;
    chk("t1.lane1", int'(prf_out[1]), 32);
    chk("t1.lane0", int'(prf_out[0]), 0);
    chk("t1.lane2", int'(prf_out[2]), 0);
    chk("t1.alloc", int'(allocatable), 1);
    step("t1a");
    chk("t1.next", int'(prf_out[1]), 33);
    step("t1b");

    // Two-lane request
    do_reset();
    prf_req = 3'b011;
    #1;
    chk("t2.l0", int'(prf_out[0]), 32);
    chk("t2.l1", int'(prf_out[1]), 33);
    step("t2a");
    chk("t2.l0n", int'(prf_out[0]), 34);
    chk("t2.l1n", int'(prf_out[1]), 35);
    step("t2b");

    // Release of p1 is visible next cycle; release of p0 ignored
    do_reset();
    prf_replace_valid = 3'b011;
    prf_replace[0] = 6'd1;
    prf_replace[1] = 6'd0;
    step("t3rel");
    idle();
    prf_req = 3'b001;
    #1;
    chk("t3.p1", int'(prf_out[0]), 1);
    step("t3a");
    chk("t3.after", int'(prf_out[0]), 32);
    step("t3b");

    // Exhaustion and freeze
    do_reset();
    prf_req = 3'b011;
    for (int i = 0; i < 16; i++) step("t4fill");
    #1;
    chk("t4.empty", int'(allocatable), 0);
    step("t4frz");
    chk("t4.still", int'(allocatable), 0);
    prf_replace_valid = 3'b001;
    prf_replace[0] = 6'd5;
    step("t4rel");
    prf_replace_valid = '0;
    prf_req = 3'b001;
    #1;
    chk("t4.p5", int'(prf_out[0]), 5);
    chk("t4.alloc", int'(allocatable), 1);
    step("t4a");

    // Checkpoint then recover
    do_reset();
    check = 1; check_idx = 2'd0;
    step("t5chk");
    check = 0;
    prf_req = 3'b011;
    step("t5a");
    step("t5b");
    prf_req = 3'b000;
    recover = 1; recover_idx = 2'd0;
    step("t5rec");
    recover = 0;
    prf_req = 3'b001;
    #1;
    chk("t5.p32", int'(prf_out[0]), 32);
    step("t5c");

    // Release and recover in the same cycle; allocation suppressed
    do_reset();
    check = 1; check_idx = 2'd1;
    step("t6chk");
    check = 0;
    prf_req = 3'b111;
    step("t6alloc");
    prf_replace_valid = 3'b111;
    prf_replace[0] = 6'd12;
    prf_replace[1] = 6'd8;
    prf_replace[2] = 6'd1;
    recover = 1; recover_idx = 2'd1;
    step("t6both");
    idle();
    prf_req = 3'b111;
    #1;
    chk("t6.l0", int'(prf_out[0]), 1);
    chk("t6.l1", int'(prf_out[1]), 8);
    chk("t6.l2", int'(prf_out[2]), 12);
    step("t6a");
    prf_req = 3'b001;
    #1;
    chk("t6.p32", int'(prf_out[0]), 32);
    step("t6b");

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      prf_req = RW'($urandom_range(0, 7));
      cand.delete();
      for (int i = 1; i < PS; i++) if (!m_free[i]) cand.push_back(i);
      for (int l = 0; l < RW; l++) begin
        if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
          prf_replace_valid[l] = 1'b1;
          prf_replace[l] = IW'(cand[$urandom_range(0, cand.size() - 1)]);
        end
      end
      if ($urandom_range(0, 9) == 0) begin check = 1; check_idx = 2'($urandom_range(0, 3)); end
      if ($urandom_range(0, 14) == 0) begin recover = 1; recover_idx = 2'($urandom_range(0, 3)); end
      if ($urandom_range(0, 199) == 0) reset = 1;
      step("rnd");
      reset = 0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
